// File: rtl/leb128_reader.sv
// LEB128 field reader: fetches bytes from a byte-wide ROM starting at start_addr
// and decodes a 32-bit unsigned (SIGNED=0) or signed (SIGNED=1) integer.
// Each byte takes an ISSUE/WAIT pair. A final FINISH cycle assembles the
// result (sign fill, next address) before the one-cycle done pulse.
module leb128_reader #(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          SIGNED    = 1'b0,
    parameter int unsigned MAX_BYTES = 5,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       value,
    output logic [2:0]        nbytes,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    input  logic [7:0]        rom_data,
    input  logic              rom_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // Watchdog counts 0..TIMEOUT-1 while waiting for the ROM.
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       acc_q,       acc_d;
    logic [2:0]        count_q,     count_d;
    logic              sign_q,      sign_d;
    logic [WD_W-1:0]   wdog_q,      wdog_d;
    logic [31:0]       value_q,     value_d;
    logic [2:0]        nbytes_q,    nbytes_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;

    // count_q is the byte index in WAIT and the byte count N in FINISH,
    // so one shift amount serves both byte placement and sign fill (7*N).
    logic [5:0]  shift_amt;
    logic [31:0] byte_bits;
    logic [31:0] sign_fill;
    logic        last_byte;
    logic        overflow;

    assign shift_amt = {3'b000, count_q} * 6'd7;
    assign byte_bits = {25'd0, rom_data[6:0]} << shift_amt;
    // A shift of 35 (N=5) yields zero, so no sign fill for a full-width field.
    assign sign_fill = (SIGNED && sign_q) ? (32'hFFFF_FFFF << shift_amt) : 32'd0;
    assign last_byte = (count_q == 3'(MAX_BYTES - 1));
    // The last byte may only carry bits that fit in 32; for s32 the unused
    // upper payload bits must replicate the sign bit (payload bit 3).
    assign overflow  = SIGNED ? (rom_data[6:4] != {3{rom_data[3]}})
                              : (rom_data[6:4] != 3'b000);

    // Next-state and datapath decisions for the byte fetch/decode sequence.
    // NOTE: every *_d is defaulted to its *_q first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sign_d      = sign_q;
        wdog_d      = wdog_q;
        value_d     = value_q;
        nbytes_d    = nbytes_q;
        next_addr_d = next_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    acc_d   = 32'd0;
                    count_d = 3'd0;
                    sign_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // rom_ready is deliberately ignored here: any pulse now belongs
                // to an earlier address.
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rom_ready) begin
                    acc_d   = acc_q | byte_bits;
                    count_d = count_q + 3'd1;
                    sign_d  = rom_data[6];
                    if (last_byte && overflow) begin
                        state_d = S_ERR;
                    end else if (!rom_data[7]) begin
                        state_d = S_FINISH;
                    end else if (last_byte) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_FINISH: begin
                value_d     = acc_q | sign_fill;
                nbytes_d    = count_q;
                next_addr_d = addr_q + ADDR_W'(1);
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            acc_q       <= 32'd0;
            count_q     <= 3'd0;
            sign_q      <= 1'b0;
            wdog_q      <= '0;
            value_q     <= 32'd0;
            nbytes_q    <= 3'd0;
            next_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            wdog_q      <= wdog_d;
            value_q     <= value_d;
            nbytes_q    <= nbytes_d;
            next_addr_q <= next_addr_d;
        end
    end

    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_FINISH);
    assign rom_read_en = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign rom_addr    = addr_q;
    assign value       = value_q;
    assign nbytes      = nbytes_q;
    assign next_addr   = next_addr_q;

endmodule
